// File: rtl/ucsbece154a_pkg.sv
// Shared encodings for the multicycle RV32I datapath: opcodes, ALU controls,
// immediate formats and mux-select values used by the datapath and controller.
package ucsbece154a_pkg;

    // Opcodes the datapath itself needs to recognise
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU control encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;

    // ALU source A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU source B select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] SRCB_ZERO  = 2'b11;

    // Result select (both upper codes pick the live ALU result)
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/ucsbece154a_rf.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous clear. x0 is never written and always reads as zero.
// There is no write-to-read bypass; the multicycle sequencing never needs one.
module ucsbece154a_rf #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1_i,
    input  logic [4:0]  a2_i,
    input  logic [4:0]  a3_i,
    input  logic        we3_i,
    input  logic [31:0] wd3_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] rf_q [NREGS];

    // Storage: cleared on reset, written on a clock edge unless the target is x0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (we3_i && (a3_i != 5'd0)) begin
            rf_q[a3_i] <= wd3_i;
        end
    end

    // Read ports with x0 forced to zero
    always_comb begin
        rd1_o = (a1_i == 5'd0) ? 32'd0 : rf_q[a1_i];
        rd2_o = (a2_i == 5'd0) ? 32'd0 : rf_q[a2_i];
    end

endmodule

// File: rtl/ucsbece154a_datapath.sv
// Multicycle RV32I datapath. Holds the architectural and inter-step registers,
// the register file, immediate extender and ALU. All sequencing comes from the
// main-FSM controller through the *_i selects; op/funct3/funct7/zero go back to it.
module ucsbece154a_datapath
    import ucsbece154a_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite_i,
    input  logic        IRWrite_i,
    input  logic        RegWrite_i,
    input  logic        AdrSrc_i,
    input  logic [1:0]  ALUSrcA_i,
    input  logic [1:0]  ALUSrcB_i,
    input  logic [1:0]  ResultSrc_i,
    input  logic [2:0]  ALUControl_i,
    input  logic [2:0]  ImmSrc_i,
    input  logic [31:0] ReadData_i,
    output logic [31:0] Adr_o,
    output logic [31:0] WriteData_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_o,
    output logic        zero_o
);

    logic [31:0] pc_q, oldpc_q, ir_q, data_q, a_q, b_q, aluout_q;
    logic [31:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;

    ucsbece154a_rf #(.NREGS(NREGS)) u_rf (
        .clk   (clk),
        .reset (reset),
        .a1_i  (ir_q[19:15]),
        .a2_i  (ir_q[24:20]),
        .a3_i  (ir_q[11:7]),
        .we3_i (RegWrite_i),
        .wd3_i (result),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

    // Inter-step registers load every cycle; PC and IR/OldPC load on enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            data_q   <= ReadData_i;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_result;
            if (PCWrite_i) pc_q <= result;
            if (IRWrite_i) begin
                ir_q    <= ReadData_i;
                oldpc_q <= pc_q;
            end
        end
    end

    // Immediate extender driven by the instruction register
    always_comb begin
        imm_ext = 32'd0;
        case (ImmSrc_i)
            IMM_I:   imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S:   imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm_ext = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            IMM_U:   imm_ext = {ir_q[31:12], 12'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    // ALU operand selection and operation; LUI bypasses the ALU with the immediate
    // because the controller leaves SrcA and the ALU control undefined in that state
    always_comb begin
        src_a = 32'd0;
        case (ALUSrcA_i)
            SRCA_PC:    src_a = pc_q;
            SRCA_OLDPC: src_a = oldpc_q;
            SRCA_A:     src_a = a_q;
            default:    src_a = 32'd0;
        endcase
        src_b = 32'd0;
        case (ALUSrcB_i)
            SRCB_B:    src_b = b_q;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = 32'd4;
            default:   src_b = 32'd0;
        endcase
        alu_result = 32'd0;
        case (ALUControl_i)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            default: alu_result = 32'd0;
        endcase
        if (ir_q[6:0] == OP_LUI) alu_result = imm_ext;
    end

    // Result mux and memory-side outputs
    always_comb begin
        result = alu_result;
        case (ResultSrc_i)
            RES_ALUOUT: result = aluout_q;
            RES_DATA:   result = data_q;
            default:    result = alu_result;
        endcase
        Adr_o       = AdrSrc_i ? result : pc_q;
        WriteData_o = b_q;
        op_o        = ir_q[6:0];
        funct3_o    = ir_q[14:12];
        funct7_o    = ir_q[30];
        zero_o      = (alu_result == 32'd0);
    end

endmodule

// File: tb/tb_ucsbece154a_datapath.sv
// Directed bench for the multicycle datapath: drives controller-style step
// sequences and checks the externally visible outputs against hand-computed values.
module tb_ucsbece154a_datapath;

    logic        clk, reset;
    logic        PCWrite_i, IRWrite_i, RegWrite_i, AdrSrc_i;
    logic [1:0]  ALUSrcA_i, ALUSrcB_i, ResultSrc_i;
    logic [2:0]  ALUControl_i, ImmSrc_i;
    logic [31:0] ReadData_i;
    logic [31:0] Adr_o, WriteData_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o;
    logic        funct7_o, zero_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_exp;

    ucsbece154a_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite_i    (PCWrite_i),
        .IRWrite_i    (IRWrite_i),
        .RegWrite_i   (RegWrite_i),
        .AdrSrc_i     (AdrSrc_i),
        .ALUSrcA_i    (ALUSrcA_i),
        .ALUSrcB_i    (ALUSrcB_i),
        .ResultSrc_i  (ResultSrc_i),
        .ALUControl_i (ALUControl_i),
        .ImmSrc_i     (ImmSrc_i),
        .ReadData_i   (ReadData_i),
        .Adr_o        (Adr_o),
        .WriteData_o  (WriteData_o),
        .op_o         (op_o),
        .funct3_o     (funct3_o),
        .funct7_o     (funct7_o),
        .zero_o       (zero_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic pcw, input logic irw, input logic rgw, input logic adr,
                            input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                            input logic [2:0] ac, input logic [2:0] im);
        PCWrite_i = pcw; IRWrite_i = irw; RegWrite_i = rgw; AdrSrc_i = adr;
        ALUSrcA_i = sa; ALUSrcB_i = sb; ResultSrc_i = rs; ALUControl_i = ac; ImmSrc_i = im;
    endtask

    task automatic idle();
        set_ctrl(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
    endtask

    // Fetch step: IR <= instr, OldPC <= PC, PC <= PC + 4
    task automatic fetch(input logic [31:0] instr);
        ReadData_i = instr;
        set_ctrl(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        tick();
        pc_exp = pc_exp + 32'd4;
        idle();
        ReadData_i = 32'd0;
    endtask

    // Decode, ExecuteI (A + ImmI), ALUWB
    task automatic exec_i_wb();
        tick();
        set_ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);
        tick();
        set_ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        ALUSrcA_i = 2'b11; ALUSrcB_i = 2'b11;
        ReadData_i = 32'd0;
        reset = 1'b1;
        #2;
        n_cmp++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL reset_adr: got %h want %h", Adr_o, 32'h0001_0000); end
        n_cmp++; if (op_o !== 7'd0) begin n_err++; $display("FAIL reset_op: got %h want 00", op_o); end
        n_cmp++; if (funct3_o !== 3'd0 || funct7_o !== 1'b0) begin n_err++; $display("FAIL reset_funct: got %h/%b want 0/0", funct3_o, funct7_o); end
        n_cmp++; if (WriteData_o !== 32'd0) begin n_err++; $display("FAIL reset_wd: got %h want 0", WriteData_o); end
        n_cmp++; if (zero_o !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", zero_o); end
        reset = 1'b0;
        tick();
        n_cmp++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL reset_hold_pc: got %h want %h", Adr_o, 32'h0001_0000); end
        pc_exp = 32'h0001_0000;
        idle();
    endtask

    task automatic test_fetch();
        // addi x1,x0,5
        ReadData_i = 32'h0050_0093;
        set_ctrl(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000);
        #1;
        n_cmp++; if (zero_o !== 1'b0) begin n_err++; $display("FAIL fetch_zero: got %b want 0", zero_o); end
        tick();
        pc_exp = pc_exp + 32'd4;
        idle();
        n_cmp++; if (op_o !== 7'h13) begin n_err++; $display("FAIL fetch_op: got %h want 13", op_o); end
        n_cmp++; if (Adr_o !== 32'h0001_0004) begin n_err++; $display("FAIL fetch_pc: got %h want %h", Adr_o, 32'h0001_0004); end
        // OldPC seen through SrcA=OldPC + 0 routed to the address port
        set_ctrl(0, 0, 0, 1, 2'b01, 2'b11, 2'b10, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'h0001_0000) begin n_err++; $display("FAIL fetch_oldpc: got %h want %h", Adr_o, 32'h0001_0000); end
        idle();
        tick();
        set_ctrl(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000);
        tick();
        set_ctrl(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd5) begin n_err++; $display("FAIL addi_aluout: got %h want 5", Adr_o); end
        tick();
        idle();
        // addi x2,x0,5
        fetch(32'h0050_0113);
        exec_i_wb();
    endtask

    task automatic test_sub_beq();
        logic [31:0] p;
        // sub x4,x1,x2
        fetch(32'h4020_8233);
        n_cmp++; if (op_o !== 7'h33 || funct7_o !== 1'b1) begin n_err++; $display("FAIL sub_decode: got op %h f7 %b want 33/1", op_o, funct7_o); end
        tick();
        n_cmp++; if (WriteData_o !== 32'd5) begin n_err++; $display("FAIL x2_value: got %h want 5", WriteData_o); end
        set_ctrl(0, 0, 0, 1, 2'b10, 2'b11, 2'b10, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd5) begin n_err++; $display("FAIL x1_value: got %h want 5", Adr_o); end
        set_ctrl(0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd0 || zero_o !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %h z=%b want 0 z=1", Adr_o, zero_o); end
        idle();
        // beq x1,x2,+8
        p = pc_exp;
        fetch(32'h0020_8463);
        set_ctrl(0, 0, 0, 1, 2'b01, 2'b01, 2'b10, 3'b000, 3'b010);
        #1;
        n_cmp++; if (Adr_o !== p + 32'd8) begin n_err++; $display("FAIL beq_target: got %h want %h", Adr_o, p + 32'd8); end
        tick();
        set_ctrl(1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000);
        #1;
        n_cmp++; if (zero_o !== 1'b1) begin n_err++; $display("FAIL beq_zero: got %b want 1", zero_o); end
        n_cmp++; if (Adr_o !== pc_exp) begin n_err++; $display("FAIL beq_pc_before: got %h want %h", Adr_o, pc_exp); end
        tick();
        idle();
        pc_exp = p + 32'd8;
        n_cmp++; if (Adr_o !== pc_exp) begin n_err++; $display("FAIL beq_taken: got %h want %h", Adr_o, pc_exp); end
    endtask

    task automatic test_lui();
        // lui x3,0x12345 (funct3 field = 5); SrcA=PC and ALUControl=slt must not matter
        fetch(32'h1234_51B7);
        tick();
        set_ctrl(0, 0, 0, 1, 2'b00, 2'b01, 2'b10, 3'b101, 3'b100);
        #1;
        n_cmp++; if (Adr_o !== 32'h1234_5000 || zero_o !== 1'b0) begin n_err++; $display("FAIL lui_pc_slt: got %h z=%b want 12345000 z=0", Adr_o, zero_o); end
        set_ctrl(0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b010, 3'b100);
        #1;
        n_cmp++; if (Adr_o !== 32'h1234_5000) begin n_err++; $display("FAIL lui_a_and: got %h want 12345000", Adr_o); end
        set_ctrl(0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 3'b011, 3'b100);
        tick();
        set_ctrl(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        tick();
        idle();
        // sw x3,0(x0) puts rf[3] into B
        fetch(32'h0030_2023);
        tick();
        n_cmp++; if (WriteData_o !== 32'h1234_5000) begin n_err++; $display("FAIL lui_x3: got %h want 12345000", WriteData_o); end
    endtask

    task automatic test_x0_slt();
        // add x0,x0,x0 then write 0xDEAD from the Data register into x0
        fetch(32'h0000_0033);
        ReadData_i = 32'h0000_DEAD;
        tick();
        ReadData_i = 32'd0;
        set_ctrl(0, 0, 1, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'h0000_DEAD) begin n_err++; $display("FAIL x0_wr_result: got %h want 0000dead", Adr_o); end
        tick();
        idle();
        tick();
        n_cmp++; if (WriteData_o !== 32'd0) begin n_err++; $display("FAIL x0_read_b: got %h want 0", WriteData_o); end
        set_ctrl(0, 0, 0, 1, 2'b10, 2'b11, 2'b10, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd0 || zero_o !== 1'b1) begin n_err++; $display("FAIL x0_read_a: got %h z=%b want 0 z=1", Adr_o, zero_o); end
        idle();
        // addi x5,x0,-1 then slti x6,x5,1
        fetch(32'hFFF0_0293);
        exec_i_wb();
        fetch(32'h0012_A313);
        tick();
        set_ctrl(0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b101, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd1) begin n_err++; $display("FAIL slt_m1_1: got %h want 1", Adr_o); end
        ALUSrcB_i = 2'b10;
        #1;
        n_cmp++; if (Adr_o !== 32'd1) begin n_err++; $display("FAIL slt_m1_4: got %h want 1", Adr_o); end
        ALUSrcB_i = 2'b01; ALUControl_i = 3'b001;
        #1;
        n_cmp++; if (Adr_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_m1_1: got %h want fffffffe", Adr_o); end
        ALUControl_i = 3'b111;
        #1;
        n_cmp++; if (Adr_o !== 32'd0) begin n_err++; $display("FAIL alu_undef: got %h want 0", Adr_o); end
        idle();
    endtask

    task automatic test_reset_mid();
        fetch(32'h4020_8233);
        tick();
        set_ctrl(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b000);
        tick();
        set_ctrl(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000);
        #1;
        n_cmp++; if (Adr_o !== 32'd10) begin n_err++; $display("FAIL execr_aluout: got %h want a", Adr_o); end
        reset = 1'b1;
        #1;
        n_cmp++; if (Adr_o !== 32'd0) begin n_err++; $display("FAIL rst_aluout: got %h want 0", Adr_o); end
        AdrSrc_i = 1'b0;
        #1;
        n_cmp++; if (Adr_o !== 32'h0001_0000 || op_o !== 7'd0) begin n_err++; $display("FAIL rst_pc: got %h op %h want 00010000 op 00", Adr_o, op_o); end
        reset = 1'b0;
        idle();
        pc_exp = 32'h0001_0000;
        // sw x1,0(x0): rf[1] must have been cleared
        fetch(32'h0010_2023);
        n_cmp++; if (Adr_o !== 32'h0001_0004) begin n_err++; $display("FAIL rst_refetch: got %h want 00010004", Adr_o); end
        tick();
        n_cmp++; if (WriteData_o !== 32'd0) begin n_err++; $display("FAIL rst_x1: got %h want 0", WriteData_o); end
    endtask

    // Test sequence and report
    initial begin
        reset = 1'b0;
        pc_exp = 32'h0001_0000;
        idle();
        ReadData_i = 32'd0;
        test_reset();
        test_fetch();
        test_sub_beq();
        test_lui();
        test_x0_slt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
